midi_uart_tx: RTL
=================

Name: midi_uart_tx

Overview:
- Serial MIDI transmitter for the synth. It is the outbound end of the MIDI link whose inbound end feeds the voice pipelines.
- Accepts bytes over a valid/ready handshake into a small FIFO, then serialises them at 31250 baud as 8N1 frames on a single output line.
- Runs entirely in the SYSTEM_CLOCK (50 MHz) domain.
- Used for MIDI THRU/echo and for sending controller feedback to external gear.

Parameters:
- CLOCK_FREQ, 50000000: input clock frequency in Hz.
- BAUD_RATE, 31250: MIDI bit rate in bits/s. Bit period BIT_TICKS = CLOCK_FREQ/BAUD_RATE = 1600 cycles (integer division).
- BYTE_WIDTH, 8: data bits per frame.
- FIFO_DEPTH, 8: byte FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clock, in, 1: system clock. All logic is on the rising edge.
- reset_l, in, 1: asynchronous, active-low reset.
- data_in, in, BYTE_WIDTH: byte to send.
- data_valid, in, 1: data_in is valid.
- data_ready, out, 1: FIFO can accept a byte.
- midi_tx, out, 1: serial line. Idle level is high.
- busy, out, 1: high while a frame is on the line or the FIFO is non-empty.
- fifo_count, out, $clog2(FIFO_DEPTH)+1: number of bytes queued, not counting the byte in flight.

Behaviour:
- Reset (reset_l low, asynchronous):
  - midi_tx=1, busy=0, data_ready=0, fifo_count=0.
  - FSM goes to IDLE; FIFO pointers and bit/tick counters clear.
  - A frame in progress is abandoned and the line goes high immediately.
  - data_ready rises on the first clock edge after reset_l deasserts.
- Handshake:
  - A byte is accepted on a rising edge where data_valid && data_ready.
  - data_ready = (fifo_count < FIFO_DEPTH). There is no push-through when full, even if a pop happens in the same cycle.
  - data_in must stay stable while data_valid is high and data_ready is low.
  - A push and a pop in the same cycle leave fifo_count unchanged.
- FSM states IDLE, START, DATA, STOP. The tick counter counts 0..BIT_TICKS-1.
  - IDLE: midi_tx=1. If the FIFO is non-empty: pop into the shift register and go to START, tick=0.
  - START: midi_tx=0 for BIT_TICKS cycles, then go to DATA, bit=0.
  - DATA: midi_tx=shift[0], LSB first. Each bit lasts BIT_TICKS cycles; shift right after each bit. After bit 7, go to STOP.
  - STOP: midi_tx=1 for BIT_TICKS cycles. When it expires:
    - if the FIFO is non-empty, pop and go directly to START on that same edge (no idle gap);
    - otherwise go to IDLE.
- Timing:
  - Byte accepted at edge k into an empty, idle block: pop at edge k+1, midi_tx falls at edge k+1.
  - Frame length is exactly 10*BIT_TICKS = 16000 cycles.
  - Back-to-back frames are contiguous.
- busy = (state != IDLE) || (fifo_count != 0). It is registered, updating on the same edges as the state.
- Counters are sized with $clog2(BIT_TICKS). The tick counter wraps to 0 at BIT_TICKS-1. FIFO pointers wrap modulo FIFO_DEPTH.
- The data path is byte-transparent: no interpretation of MIDI content unless the optional feature is compiled in.

Optional Feature:
- Macro: MIDI_RUNNING_STATUS_EN.
- When defined, the block tracks last_status, an 8-bit register cleared to 0x00 at reset. Each time a byte is popped:
  - 0x80–0xEF (channel status): if equal to last_status, the byte is discarded and the FSM behaves as if that pop found the byte absent (pops the next byte or goes to IDLE). Otherwise it is transmitted and last_status is set to the byte.
  - 0xF0–0xF7 (system common/SysEx): transmitted; last_status cleared to 0x00.
  - 0xF8–0xFF (realtime): transmitted; last_status unchanged.
  - 0x00–0x7F (data): transmitted; last_status unchanged.
  - A discarded byte consumes exactly one cycle of pop evaluation and does not count as a frame.
- When not defined, all bytes are transmitted verbatim and no last_status register exists.

Test Plan:
- Single byte: push 0x90 at edge k into an idle block.
  - midi_tx is low from k+1 to k+1600.
  - Data bits 0,0,0,0,1,0,0,1 follow, 1600 cycles each.
  - Stop bit is high.
  - busy falls at edge k+16001.
- Back-to-back: push 0x90, 0x3C, 0x64 on consecutive cycles.
  - Three contiguous frames totalling 48000 cycles, with no high gap between stop and start.
  - busy stays high throughout and fifo_count steps 2→1→0.
- Full FIFO: hold data_valid high with an incrementing byte 0x00.. from idle.
  - 9 bytes are accepted (1 in flight + 8 queued), then data_ready=0.
  - data_ready reasserts 1 cycle after the next pop.
  - Output order is 0x00..0x08.
- Reset mid-frame: assert reset_l low during DATA bit 3 of 0xA5 with 3 bytes queued.
  - midi_tx goes high asynchronously; fifo_count=0; busy=0.
  - No further frames after release.
  - A fresh 0x55 sends correctly.
- MIDI_RUNNING_STATUS_EN: push 0x90,0x3C,0x64,0x90,0x40,0x64,0xF8,0x90,0x43,0x64.
  - Frames sent are 0x90,0x3C,0x64,0x40,0x64,0xF8,0x43,0x64.
  - Without the macro, all 10 bytes are sent.
- MIDI_RUNNING_STATUS_EN: push 0x90,0xF2,0x90.
  - All three are sent, because 0xF2 clears running status.

Source files
------------

// File: rtl/midi_uart_tx.sv
// midi_uart_tx: 8N1 serial MIDI transmitter fed by a valid/ready byte FIFO.
// Optional build macro MIDI_RUNNING_STATUS_EN drops channel-status bytes that repeat the running status.
module midi_uart_tx #(
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned BAUD_RATE  = 31250,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset_l,
  input  logic [BYTE_WIDTH-1:0]         data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          midi_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned BIT_TICKS = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned TICK_W    = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int unsigned BIT_W     = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BYTE_WIDTH - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [BYTE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count_q, count_next;
  logic [BYTE_WIDTH-1:0] head;
  logic                  push, pop, fifo_empty;

  state_t                state_q, state_next;
  logic [TICK_W-1:0]     tick_q, tick_next;
  logic [BIT_W-1:0]      bit_q, bit_next;
  logic [BYTE_WIDTH-1:0] shift_q, shift_next;
  logic                  tick_done, try_pop, send_ok;
  logic                  tx_q, tx_next, busy_q, ready_q;

  assign head       = mem[rd_ptr];
  assign fifo_empty = (count_q == '0);
  assign push       = data_valid && ready_q;
  assign pop        = try_pop;
  assign tick_done  = (tick_q == TICK_LAST);

  assign data_ready = ready_q;
  assign midi_tx    = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

  // ---------------- byte FIFO ----------------
  always_comb begin
    count_next = count_q;
    if (push && !pop)
      count_next = count_q + CNT_W'(1);
    else if (!push && pop)
      count_next = count_q - CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_next;
    end
  end

  // ---------------- running status filter ----------------
`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status, head8;
  logic       is_chan, is_sys;

  assign head8   = 8'(head);
  assign is_chan = (head8 >= 8'h80) && (head8 <= 8'hEF);
  assign is_sys  = (head8 >= 8'hF0) && (head8 <= 8'hF7);
  assign send_ok = !(is_chan && (head8 == last_status));

  // A discarded byte equals last_status already, so updating on every channel pop is safe.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l)
      last_status <= '0;
    else if (pop) begin
      if (is_chan)
        last_status <= head8;
      else if (is_sys)
        last_status <= '0;
    end
  end
`else
  assign send_ok = 1'b1;
`endif

  // ---------------- frame FSM ----------------
  always_comb begin
    state_next = state_q;
    tick_next  = tick_q;
    bit_next   = bit_q;
    shift_next = shift_q;
    try_pop    = 1'b0;
    tx_next    = 1'b1;

    case (state_q)
      IDLE: try_pop = !fifo_empty;
      START: begin
        if (tick_done) begin
          state_next = DATA;
          tick_next  = '0;
          bit_next   = '0;
        end else
          tick_next = tick_q + 1'b1;
      end
      DATA: begin
        if (tick_done) begin
          tick_next  = '0;
          shift_next = shift_q >> 1;
          if (bit_q == BIT_LAST)
            state_next = STOP;
          else
            bit_next = bit_q + 1'b1;
        end else
          tick_next = tick_q + 1'b1;
      end
      STOP: begin
        if (tick_done) begin
          tick_next  = '0;
          state_next = IDLE;
          try_pop    = !fifo_empty;
        end else
          tick_next = tick_q + 1'b1;
      end
      default: state_next = IDLE;
    endcase

    // A discarded pop leaves the FSM in IDLE, so the next byte is evaluated one cycle later.
    if (try_pop && send_ok) begin
      state_next = START;
      tick_next  = '0;
      shift_next = head;
    end

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_next;
      tick_q  <= tick_next;
      bit_q   <= bit_next;
      shift_q <= shift_next;
      tx_q    <= tx_next;
      busy_q  <= (state_next != IDLE) || (count_next != '0);
      ready_q <= (count_next < DEPTH_C);
    end
  end

endmodule
